pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline built around the decode/control unit. It computes EX-stage forwarding selects and detects load-use hazards. It flushes wrong-path instructions on a taken branch or jump, and freezes the pipeline while a data-memory access waits for `mem_ready`. A timeout drives the core into a sticky error state. It also keeps a saturating stall-cycle counter for performance checks.

## Interface
- `MAX_WAIT`, 16: maximum number of cycles spent in MEM_WAIT before ERROR. Legal range 2..255.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_D`, `rs2_D`  in  5 each  source registers of the instruction in decode.
- `rs1_E`, `rs2_E`, `rd_E`  in  5 each  register fields of the instruction in execute.
- `MemRead_E`  in  1  the instruction in execute is a load.
- `PCSrc_E`  in  1  branch taken or jump resolved in execute.
- `rd_M`, `RegWrite_M`, `MemRead_M`, `MemWrite_M`  in  5/1/1/1  memory-stage fields.
- `rd_W`, `RegWrite_W`  in  5/1  writeback-stage fields.
- `mem_ready`  in  1  data memory completes the current access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each  hold the pipeline register feeding that stage.
- `FlushD`, `FlushE`, `FlushW`  out  1 each  load a bubble into that stage register.
- `ForwardAE`, `ForwardBE`  out  2 each  select for ALU operand A/B: 00 register file, 01 writeback result, 10 memory-stage ALU result.
- `mem_req`  out  1  data-memory request.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  32  count of cycles with `StallF`=1, saturating.

## Operation
- States: RUN, MEM_WAIT, ERROR.

**Forwarding** (combinational, in every state)
- `ForwardAE`=10 if `RegWrite_M` && `rd_M`!=0 && `rd_M`==`rs1_E`.
- Otherwise `ForwardAE`=01 if `RegWrite_W` && `rd_W`!=0 && `rd_W`==`rs1_E`.
- Otherwise `ForwardAE`=00.
- `ForwardBE` is identical with `rs2_E`. The M stage has priority over W.

**Memory request**
- `mem_acc` = `MemRead_M` | `MemWrite_M`.
- `mem_req` = `mem_acc` && state∈{RUN, MEM_WAIT}.

**RUN**
- Priority 1, `mem_acc` && !`mem_ready`:
  - Go to MEM_WAIT.
  - StallF/D/E/M=1 and FlushW=1 this cycle.
  - Branch and load-use outputs are suppressed.
- Priority 2, `PCSrc_E`:
  - FlushD=1 and FlushE=1; no stall.
  - A simultaneous load-use condition is ignored, because the dependent instruction is flushed.
- Priority 3, load-use:
  - Condition: `MemRead_E` && `rd_E`!=0 && (`rd_E`==`rs1_D` || `rd_E`==`rs2_D`).
  - Response: StallF=1, StallD=1, FlushE=1, for exactly one cycle.
- Otherwise all stall and flush outputs are 0.

**MEM_WAIT**
- Increment `wait_cnt` (8 bits; cleared on entry to MEM_WAIT).
- If `mem_ready`=1: all stalls and flushes are 0 this cycle (the access completes); next state RUN. `mem_ready` wins over timeout in the same cycle.
- Else if `wait_cnt`==`MAX_WAIT`-1: next state ERROR; set `mem_err`.
- Else: StallF/D/E/M=1 and FlushW=1. `PCSrc_E` and load-use are masked and re-evaluated after the return to RUN.

**ERROR**
- StallF/D/E/M=1, FlushW=1, `mem_req`=0, `mem_err`=1.
- Only reset exits this state.

**Counter**
- `stall_cnt` increments on every cycle with `StallF`=1.
- It holds at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous assert; deassert sampled on the next `clk`):
  - State RUN; `wait_cnt`, `stall_cnt` and `mem_err` are 0.
  - While `rst_n`=0, all outputs are 0, including the forward selects and `mem_req`.
- Reset mid-MEM_WAIT or in ERROR returns to RUN immediately, with no request pending.
- Forwarding, flush, load-use and `mem_req` outputs are combinational from inputs and current state, with zero latency.
- The load-use stall costs 1 cycle.
- A memory access whose `mem_ready` arrives N cycles after the first `mem_req` costs N stall cycles:
  - N=0 means no stall.
  - At most `MAX_WAIT` cycles are spent in MEM_WAIT before ERROR.
- `mem_req` stays high continuously from first assertion until the cycle `mem_ready`=1.

## Structure
- Package `pipe_ctrl_pkg`:
  - state enum `pctrl_state_t` {RUN, MEM_WAIT, ERROR};
  - forward-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10.
- Sub-module `forward_unit`: purely combinational; instantiated once, producing `ForwardAE` and `ForwardBE`.
- FSM, `wait_cnt`, `stall_cnt` and `mem_err` live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `MemRead_E`=1, `rd_E`=5, `rs2_D`=5 → one cycle of StallF=StallD=FlushE=1, then all 0. Repeat with `rd_E`=0 → no stall.
- **Forward priority:** `rs1_E`=3, `rd_M`=`rd_W`=3, both RegWrite=1 → `ForwardAE`=10. Drop `RegWrite_M` → 01.
- **Branch vs. load-use:** `PCSrc_E`=1 together with a load-use condition → FlushD=FlushE=1 and StallF=0. `stall_cnt` unchanged.
- **Memory wait:** `MemRead_M`=1, `mem_ready` raised on the 3rd cycle → `mem_req` high for 3 cycles, stalls high for 2, `stall_cnt`=2, state back to RUN.
- **Timeout:** `MAX_WAIT`=4, `mem_ready` held low → ERROR after 4 cycles in MEM_WAIT; `mem_err`=1 and `mem_req`=0. `mem_ready`=1 in the 4th wait cycle → RUN, no error.
- **Reset mid-wait:** `rst_n`=0 asynchronously during MEM_WAIT → all outputs 0 immediately; after release, state RUN and `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } pctrl_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // The M stage holds the younger result, so it wins over W.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Combinational EX-stage operand forwarding selects.
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_E,
   input  logic [4:0] rs2_E,
   input  logic [4:0] rd_M,
   input  logic       RegWrite_M,
   input  logic [4:0] rd_W,
   input  logic       RegWrite_W,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   assign fwd_a = fwd_sel(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
   assign fwd_b = fwd_sel(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: forwarding, load-use stall, branch flush, memory-wait
// freeze with timeout into a sticky error state, and a stall-cycle counter.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs1_D,
   input  logic [4:0]  rs2_D,
   input  logic [4:0]  rs1_E,
   input  logic [4:0]  rs2_E,
   input  logic [4:0]  rd_E,
   input  logic        MemRead_E,
   input  logic        PCSrc_E,
   input  logic [4:0]  rd_M,
   input  logic        RegWrite_M,
   input  logic        MemRead_M,
   input  logic        MemWrite_M,
   input  logic [4:0]  rd_W,
   input  logic        RegWrite_W,
   input  logic        mem_ready,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        mem_req,
   output logic        mem_err,
   output logic [31:0] stall_cnt
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   pctrl_state_t state_reg, state_next;
   logic [7:0]   wait_cnt_reg;
   logic [31:0]  stall_cnt_reg;
   logic         mem_err_reg;

   logic [1:0] fwd_a, fwd_b;
   logic       mem_acc, load_use;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w, req;

   forward_unit u_forward (
      .rs1_E      (rs1_E),
      .rs2_E      (rs2_E),
      .rd_M       (rd_M),
      .RegWrite_M (RegWrite_M),
      .rd_W       (rd_W),
      .RegWrite_W (RegWrite_W),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   assign mem_acc  = MemRead_M | MemWrite_M;
   assign load_use = MemRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

   always_comb begin
      state_next = state_reg;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;
      req        = 1'b0;
      unique case (state_reg)
         RUN: begin
            req = mem_acc;
            if (mem_acc && !mem_ready) begin
               state_next = MEM_WAIT;
               {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            end else if (PCSrc_E) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         MEM_WAIT: begin
            req = mem_acc;
            if (mem_ready) begin
               state_next = RUN;
            end else begin
               // The timeout cycle still freezes: the access never completed.
               if (wait_cnt_reg == WAIT_LAST)
                  state_next = ERROR;
               {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            end
         end
         ERROR: begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         wait_cnt_reg  <= 8'd0;
         stall_cnt_reg <= 32'd0;
         mem_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg != MEM_WAIT)
            wait_cnt_reg <= 8'd0;
         else
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
         if (stall_f && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (state_next == ERROR)
            mem_err_reg <= 1'b1;
      end
   end

   // Every output is forced low while reset is held, even the combinational ones.
   assign StallF    = rst_n & stall_f;
   assign StallD    = rst_n & stall_d;
   assign StallE    = rst_n & stall_e;
   assign StallM    = rst_n & stall_m;
   assign FlushD    = rst_n & flush_d;
   assign FlushE    = rst_n & flush_e;
   assign FlushW    = rst_n & flush_w;
   assign mem_req   = rst_n & req;
   assign ForwardAE = rst_n ? fwd_a : FWD_RF;
   assign ForwardBE = rst_n ? fwd_b : FWD_RF;
   assign mem_err   = mem_err_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl (instantiated with MAX_WAIT=4).
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic        MemRead_E, PCSrc_E, RegWrite_M, MemRead_M, MemWrite_M, RegWrite_W, mem_ready;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        mem_req, mem_err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E),
      .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
      .rd_W(rd_W), .RegWrite_W(RegWrite_W), .mem_ready(mem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_req(mem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   task automatic clear_inputs();
      rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
      MemRead_E = 0; PCSrc_E = 0; RegWrite_M = 0; MemRead_M = 0; MemWrite_M = 0;
      RegWrite_W = 0; mem_ready = 0;
   endtask

   // Advance to just after the next rising edge, where new inputs are applied.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] ctl;
      rst_n = 0;
      clear_inputs();
      RegWrite_M = 1; rd_M = 3; rs1_E = 3; rs2_E = 3; MemRead_M = 1; PCSrc_E = 1;
      #2;
      ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_req, mem_err};
      checks++; if (ctl !== 9'd0) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 9'd0); end
      checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
      @(negedge clk);
      clear_inputs();
      rst_n = 1;
      next_cycle();
      $display("test_reset done");
   endtask

   task automatic test_forwarding();
      rs1_E = 3; rd_M = 3; rd_W = 3; RegWrite_M = 1; RegWrite_W = 1;
      @(negedge clk);
      checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got=%b exp=10", ForwardAE); end
      next_cycle();
      RegWrite_M = 0;
      @(negedge clk);
      checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_wb got=%b exp=01", ForwardAE); end
      next_cycle();
      clear_inputs();
      rs2_E = 7; rd_M = 7; RegWrite_M = 1; rd_W = 9; RegWrite_W = 1; rs1_E = 9;
      @(negedge clk);
      checks++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin errors++; $display("FAIL fwd_ab got=%b exp=0110", {ForwardAE, ForwardBE}); end
      next_cycle();
      clear_inputs();
      rs1_E = 0; rs2_E = 0; rd_M = 0; RegWrite_M = 1; rd_W = 0; RegWrite_W = 1;
      @(negedge clk);
      checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got=%b exp=0000", {ForwardAE, ForwardBE}); end
      next_cycle();
      clear_inputs();
      $display("test_forwarding done");
   endtask

   task automatic test_load_use();
      logic [31:0] c0;
      c0 = stall_cnt;
      MemRead_E = 1; rd_E = 5; rs2_D = 5; rs1_D = 1;
      @(negedge clk);
      checks++; if ({StallF, StallD, FlushE, StallE, StallM, FlushD} !== 6'b111000) begin errors++;
         $display("FAIL load_use got=%b exp=111000", {StallF, StallD, FlushE, StallE, StallM, FlushD}); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL load_use_after got=%b exp=000", {StallF, StallD, FlushE}); end
      checks++; if (stall_cnt !== c0 + 32'd1) begin errors++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, c0 + 32'd1); end
      next_cycle();
      MemRead_E = 1; rd_E = 0; rs1_D = 0; rs2_D = 0;
      @(negedge clk);
      checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL load_use_x0 got=%b exp=000", {StallF, StallD, FlushE}); end
      next_cycle();
      clear_inputs();
      $display("test_load_use done");
   endtask

   task automatic test_branch_vs_load_use();
      logic [31:0] c0;
      c0 = stall_cnt;
      PCSrc_E = 1; MemRead_E = 1; rd_E = 6; rs1_D = 6;
      @(negedge clk);
      checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin errors++;
         $display("FAIL branch_flush got=%b exp=1100", {FlushD, FlushE, StallF, StallD}); end
      next_cycle();
      clear_inputs();
      checks++; if (stall_cnt !== c0) begin errors++; $display("FAIL branch_cnt got=%0d exp=%0d", stall_cnt, c0); end
      $display("test_branch_vs_load_use done");
   endtask

   task automatic test_mem_wait();
      logic [31:0] c0;
      MemRead_M = 1; mem_ready = 1;
      @(negedge clk);
      checks++; if ({mem_req, StallF, StallM, FlushW} !== 4'b1000) begin errors++;
         $display("FAIL mem_n0 got=%b exp=1000", {mem_req, StallF, StallM, FlushW}); end
      next_cycle();
      c0 = stall_cnt;
      mem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if ({mem_req, StallF, StallD, StallE, StallM, FlushW} !== 6'b111111) begin errors++;
            $display("FAIL mem_wait%0d got=%b exp=111111", i, {mem_req, StallF, StallD, StallE, StallM, FlushW}); end
         next_cycle();
      end
      mem_ready = 1;
      @(negedge clk);
      checks++; if ({mem_req, StallF, StallM, FlushW} !== 4'b1000) begin errors++;
         $display("FAIL mem_done got=%b exp=1000", {mem_req, StallF, StallM, FlushW}); end
      next_cycle();
      clear_inputs();
      PCSrc_E = 1;
      @(negedge clk);
      checks++; if ({FlushD, StallF, mem_req} !== 3'b100) begin errors++; $display("FAIL mem_back_run got=%b exp=100", {FlushD, StallF, mem_req}); end
      checks++; if (stall_cnt !== c0 + 32'd2) begin errors++; $display("FAIL mem_cnt got=%0d exp=%0d", stall_cnt, c0 + 32'd2); end
      next_cycle();
      clear_inputs();
      $display("test_mem_wait done");
   endtask

   task automatic test_timeout();
      MemWrite_M = 1;
      // One RUN cycle plus four MEM_WAIT cycles with mem_ready low.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if ({mem_req, StallF, mem_err} !== 3'b110) begin errors++;
            $display("FAIL timeout_wait%0d got=%b exp=110", i, {mem_req, StallF, mem_err}); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if ({mem_req, mem_err, StallF, StallM, FlushW} !== 5'b01111) begin errors++;
         $display("FAIL timeout_err got=%b exp=01111", {mem_req, mem_err, StallF, StallM, FlushW}); end
      next_cycle();
      mem_ready = 1;
      @(negedge clk);
      checks++; if ({mem_req, mem_err, StallF} !== 3'b011) begin errors++;
         $display("FAIL err_sticky got=%b exp=011", {mem_req, mem_err, StallF}); end
      #1 rst_n = 0;
      #1;
      checks++; if ({mem_err, StallF, FlushW, stall_cnt} !== 35'd0) begin errors++;
         $display("FAIL err_reset got=%b/%0d exp=0/0", {mem_err, StallF, FlushW}, stall_cnt); end
      #1 rst_n = 1;
      clear_inputs();
      next_cycle();
      MemWrite_M = 1;
      for (int i = 0; i < 4; i++) next_cycle();
      mem_ready = 1;
      @(negedge clk);
      checks++; if ({mem_req, StallF, mem_err} !== 3'b100) begin errors++;
         $display("FAIL late_ready got=%b exp=100", {mem_req, StallF, mem_err}); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if ({mem_err, StallF, stall_cnt} !== 34'd4) begin errors++;
         $display("FAIL late_ready_run got=%b/%0d exp=00/4", {mem_err, StallF}, stall_cnt); end
      next_cycle();
      $display("test_timeout done");
   endtask

   task automatic test_reset_mid_wait();
      MemRead_M = 1; RegWrite_M = 1; rd_M = 4; rs1_E = 4;
      next_cycle();
      next_cycle();
      #1 rst_n = 0;
      #1;
      checks++; if ({StallF, StallD, StallE, StallM, FlushW, mem_req, ForwardAE} !== 8'd0) begin errors++;
         $display("FAIL rst_mid_out got=%b exp=00000000", {StallF, StallD, StallE, StallM, FlushW, mem_req, ForwardAE}); end
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      next_cycle();
      PCSrc_E = 1;
      @(negedge clk);
      checks++; if ({FlushD, StallF, mem_req} !== 3'b100) begin errors++; $display("FAIL rst_mid_run got=%b exp=100", {FlushD, StallF, mem_req}); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
      next_cycle();
      clear_inputs();
      $display("test_reset_mid_wait done");
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
